fetch_multi: RTL and testbench
==============================

FETCH_MULTI -- requirements
Module: fetch_multi

Interface
REQ-001 Parameter P_DEPTH, 4, instruction buffer entries; power of two, 2..16.
REQ-002 Parameter P_RESET_PC, 32'h00000000, first fetch address after reset.
REQ-003 Parameter P_MAX_OUTSTANDING, 4, maximum in-flight memory requests; 1..P_DEPTH.
REQ-004 iCLOCK in 1 clock; iRESET in 1 reset, asynchronous, active-high.
REQ-005 iFLUSH in 1 flushes the buffer and stops issue until a redirect arrives; iREDIRECT_VALID in 1 and iREDIRECT_ADDR in 32 give the new fetch PC.
REQ-006 iKERNEL_MODE in 1 and iPAGING_ENA in 1 are the mode flags captured per request.
REQ-007 oMEM_REQ out 1 and oMEM_ADDR out 32 form the request; iMEM_BUSY in 1 refuses the request.
REQ-008 iMEM_VALID in 1, iMEM_INST in 32, iMEM_PAGEFAULT in 1, iMEM_PRED_TAKEN in 1 and iMEM_PRED_ADDR in 32 form the in-order response; it cannot be stalled.
REQ-009 oNEXT_VALID out 1, oNEXT_INST out 32, oNEXT_PC out 32, oNEXT_PAGEFAULT out 1, oNEXT_KERNEL out 1, oNEXT_PAGING out 1, oNEXT_PREDICT out 1 and oNEXT_PREDICT_ADDR out 32 are the head entry; iNEXT_LOCK in 1 holds the head.
REQ-010 iFETCH_STOP in 1 suppresses new requests without flushing.

Function
REQ-011 States: START, FETCH, WAIT; START goes to FETCH one cycle after reset, with pc=P_RESET_PC.
REQ-012 In FETCH, oMEM_REQ=!iFETCH_STOP && !iFLUSH && !iREDIRECT_VALID && outstanding<P_MAX_OUTSTANDING && outstanding+count<P_DEPTH (credit rule); oMEM_ADDR=pc.
REQ-013 A request is accepted when oMEM_REQ && !iMEM_BUSY; then pc+=4 (mod 2^32), outstanding increments, and {kernel,paging,pc} is pushed into the address queue.
REQ-014 Each iMEM_VALID pops the address queue and decrements outstanding; if kill>0, the response is dropped and kill decrements; otherwise the entry is written into the buffer.
REQ-015 A pop or write and an accept in the same cycle leave outstanding unchanged.
REQ-016 The head is consumed when oNEXT_VALID && !iNEXT_LOCK; the buffer is a FIFO with oNEXT_* driven combinationally from the head entry.
REQ-017 oNEXT_PC is the address of the instruction itself.
REQ-018 iREDIRECT_VALID has priority over iFLUSH: pc<={ADDR[31:2],2'b00}, the buffer is cleared, kill<=outstanding minus any response arriving that cycle, the state goes to FETCH, and nothing is issued that cycle.
REQ-019 iFLUSH alone clears the buffer, sets kill as in REQ-018, and enters WAIT; in WAIT only a redirect leaves, and responses are still drained.
REQ-020 A response coinciding with a redirect or flush is dropped, not buffered.
REQ-021 The credit rule guarantees buffer space, so an overflow never occurs; the bench asserts count<=P_DEPTH.

Reset
REQ-022 iRESET asynchronously forces: state START, pc=P_RESET_PC, count=0, outstanding=0, kill=0, oNEXT_VALID=0, oMEM_REQ=0, oNEXT_PREDICT=0.
REQ-023 All data outputs read 0 while the buffer is empty; reset mid-transaction discards all in-flight state, and responses arriving after release while outstanding=0 are ignored.

Configuration
REQ-024 Macro FETCH_MULTI_PREDICT_EN: defined means a non-dropped response with iMEM_PRED_TAKEN is buffered with predict=1 and predict_addr.
REQ-025 With FETCH_MULTI_PREDICT_EN defined, that response also makes pc<={iMEM_PRED_ADDR[31:2],2'b00}, kill<=outstanding-1, and suppresses issue that cycle.
REQ-026 With FETCH_MULTI_PREDICT_EN defined, an external redirect in the same cycle wins.
REQ-027 Undefined: the iMEM_PRED_* inputs are ignored and oNEXT_PREDICT=0 and oNEXT_PREDICT_ADDR=0 are constant.

Structure
REQ-028 A shared package fetch_multi_pkg holds the state encoding (START=2'd0, FETCH=2'd1, WAIT=2'd2) and the buffer-entry field widths (entry 100 bits: inst 32, pc 32, pf, kernel, paging, predict, predict_addr 32 minus unused bits per macro).
REQ-029 The sub-module fetch_multi_fifo (parameterised width/depth, synchronous clear, count output) is instantiated twice, as the address queue and the instruction buffer.
REQ-030 Counter widths are $clog2(P_DEPTH)+1.

Verification
REQ-031 Reset release, iMEM_BUSY=0, one-cycle response -> requests 0x0,0x4,0x8,...; oNEXT_PC follows the same sequence, with no gaps while iNEXT_LOCK=0.
REQ-032 iNEXT_LOCK=1 for 20 cycles, P_DEPTH=4 -> exactly 4 requests accepted, then oMEM_REQ=0; the first unlock cycle re-raises oMEM_REQ one cycle after the pop.
REQ-033 Three requests outstanding, then iREDIRECT_VALID with ADDR=0x1003 -> the next request address is 0x1000, the three old responses are dropped, and the first oNEXT_PC is 0x1000.
REQ-034 iFLUSH in FETCH, then 10 idle cycles, then a redirect to 0x200 -> oMEM_REQ=0 throughout WAIT and fetch resumes at 0x200.
REQ-035 With FETCH_MULTI_PREDICT_EN defined, a response at 0x8 with PRED_TAKEN, PRED_ADDR=0x40 and responses 0xC,0x10 in flight -> the buffer holds 0x8 with predict=1, 0xC and 0x10 are dropped, and the next is 0x40.
REQ-036 Assert iRESET with two requests outstanding, then release -> outputs are at reset values and the late responses are not buffered.

Source files
------------

// File: rtl/fetch_multi_pkg.sv
// Shared definitions for the multi-outstanding instruction fetch unit.
// Optional feature macro: FETCH_MULTI_PREDICT_EN adds the branch-prediction
// fields to each buffered entry and enables predicted redirects.
package fetch_multi_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int INST_W      = 32;
    localparam int PC_W        = 32;
    localparam int PRED_ADDR_W = 32;
    localparam int FLAG_W      = 3;

`ifdef FETCH_MULTI_PREDICT_EN
    localparam int PRED_W = 1 + PRED_ADDR_W;
`else
    localparam int PRED_W = 0;
`endif

    // Full entry is 100 bits with prediction, 67 bits without
    localparam int ENTRY_W = INST_W + PC_W + FLAG_W + PRED_W;
    localparam int REQ_W   = PC_W + 2;

    // Per-request bookkeeping held while a memory access is in flight
    typedef struct packed {
        logic            kernel;
        logic            paging;
        logic [PC_W-1:0] pc;
    } req_t;

    // One instruction buffer entry
    typedef struct packed {
`ifdef FETCH_MULTI_PREDICT_EN
        logic                   predict;
        logic [PRED_ADDR_W-1:0] predict_addr;
`endif
        logic                   pagefault;
        logic                   kernel;
        logic                   paging;
        logic [PC_W-1:0]        pc;
        logic [INST_W-1:0]      inst;
    } entry_t;

    // Fetch addresses are always word aligned
    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_multi_fifo.sv
// Small synchronous FIFO with a combinational head, a synchronous clear and
// an occupancy count. Used both as the in-flight address queue and as the
// instruction buffer of fetch_multi.
module fetch_multi_fifo
    import fetch_multi_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok    = pop && (count != '0);
    assign push_ok   = push && ((count != FULL_CNT) || pop_ok);
    assign head_data = mem[rd_ptr];

    // Storage array; a clear in the same cycle discards the incoming word
    always_ff @(posedge clock) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_multi.sv
// Multi-outstanding instruction fetch unit: issues sequential word fetches
// under a credit rule, matches in-order responses against an address queue,
// discards responses belonging to abandoned streams and presents buffered
// instructions in order.
// Optional feature macro: FETCH_MULTI_PREDICT_EN (predicted-taken responses
// redirect the fetch stream and carry their prediction to the consumer).
module fetch_multi
    import fetch_multi_pkg::*;
#(
    parameter int          P_DEPTH           = 4,
    parameter logic [31:0] P_RESET_PC        = 32'h0000_0000,
    parameter int          P_MAX_OUTSTANDING = 4
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iFLUSH,
    input  logic        iREDIRECT_VALID,
    input  logic [31:0] iREDIRECT_ADDR,
    input  logic        iKERNEL_MODE,
    input  logic        iPAGING_ENA,
    output logic        oMEM_REQ,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_BUSY,
    input  logic        iMEM_VALID,
    input  logic [31:0] iMEM_INST,
    input  logic        iMEM_PAGEFAULT,
    input  logic        iMEM_PRED_TAKEN,
    input  logic [31:0] iMEM_PRED_ADDR,
    output logic        oNEXT_VALID,
    output logic [31:0] oNEXT_INST,
    output logic [31:0] oNEXT_PC,
    output logic        oNEXT_PAGEFAULT,
    output logic        oNEXT_KERNEL,
    output logic        oNEXT_PAGING,
    output logic        oNEXT_PREDICT,
    output logic [31:0] oNEXT_PREDICT_ADDR,
    input  logic        iNEXT_LOCK,
    input  logic        iFETCH_STOP
);

    localparam int CNT_W = $clog2(P_DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(P_DEPTH);
    localparam logic [CNT_W-1:0] MAX_OUT   = CNT_W'(P_MAX_OUTSTANDING);

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [CNT_W-1:0] kill_q;
    logic [CNT_W-1:0] kill_d;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] kill_after;

    req_t             aq_push;
    req_t             aq_head;
    entry_t           buf_push;
    entry_t           buf_head;

    logic             resp_fire;
    logic             resp_keep;
    logic             drop_kill;
    logic             clear_buf;
    logic             credit_ok;
    logic             mem_req;
    logic             accept;
    logic             next_valid;
    logic             pop_head;
    logic             pred_hit;
    logic [31:0]      pred_target;

    // Responses only count while something is actually in flight, so stale
    // responses after a reset are ignored.
    assign resp_fire  = iMEM_VALID && (outstanding != '0);
    assign drop_kill  = (kill_q != '0);
    assign clear_buf  = iREDIRECT_VALID || iFLUSH;
    assign resp_keep  = resp_fire && !drop_kill && !clear_buf;
    assign kill_after = resp_fire ? (outstanding - CNT_W'(1)) : outstanding;

`ifdef FETCH_MULTI_PREDICT_EN
    assign pred_hit    = resp_keep && iMEM_PRED_TAKEN;
    assign pred_target = align_word(iMEM_PRED_ADDR);
`else
    logic unused_pred;
    assign pred_hit    = 1'b0;
    assign pred_target = 32'h0;
    assign unused_pred = ^{iMEM_PRED_TAKEN, iMEM_PRED_ADDR};
`endif

    // Issue only when the buffer is guaranteed room for every in-flight word
    assign credit_ok = (outstanding < MAX_OUT) &&
                       (({1'b0, outstanding} + {1'b0, count}) < DEPTH_LIM);
    assign mem_req   = (state_q == FETCH) && !iFETCH_STOP && !iFLUSH &&
                       !iREDIRECT_VALID && credit_ok && !pred_hit;
    assign accept    = mem_req && !iMEM_BUSY;

    assign next_valid = (count != '0);
    assign pop_head   = next_valid && !iNEXT_LOCK;

    assign oMEM_REQ  = mem_req;
    assign oMEM_ADDR = pc_q;

    assign aq_push.kernel = iKERNEL_MODE;
    assign aq_push.paging = iPAGING_ENA;
    assign aq_push.pc     = pc_q;

    assign buf_push.inst      = iMEM_INST;
    assign buf_push.pc        = aq_head.pc;
    assign buf_push.pagefault = iMEM_PAGEFAULT;
    assign buf_push.kernel    = aq_head.kernel;
    assign buf_push.paging    = aq_head.paging;
`ifdef FETCH_MULTI_PREDICT_EN
    assign buf_push.predict      = iMEM_PRED_TAKEN;
    assign buf_push.predict_addr = iMEM_PRED_ADDR;
`endif

    // In-flight request addresses; its occupancy is the outstanding count
    fetch_multi_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (P_DEPTH)
    ) u_addrq (
        .clock     (iCLOCK),
        .reset     (iRESET),
        .clear     (1'b0),
        .push      (accept),
        .push_data (aq_push),
        .pop       (resp_fire),
        .head_data (aq_head),
        .count     (outstanding)
    );

    // Instruction buffer presented to the consumer
    fetch_multi_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (P_DEPTH)
    ) u_ibuf (
        .clock     (iCLOCK),
        .reset     (iRESET),
        .clear     (clear_buf),
        .push      (resp_keep),
        .push_data (buf_push),
        .pop       (pop_head),
        .head_data (buf_head),
        .count     (count)
    );

    // Head entry outputs read zero whenever the buffer is empty
    assign oNEXT_VALID     = next_valid;
    assign oNEXT_INST      = next_valid ? buf_head.inst : 32'h0;
    assign oNEXT_PC        = next_valid ? buf_head.pc : 32'h0;
    assign oNEXT_PAGEFAULT = next_valid && buf_head.pagefault;
    assign oNEXT_KERNEL    = next_valid && buf_head.kernel;
    assign oNEXT_PAGING    = next_valid && buf_head.paging;
`ifdef FETCH_MULTI_PREDICT_EN
    assign oNEXT_PREDICT      = next_valid && buf_head.predict;
    assign oNEXT_PREDICT_ADDR = next_valid ? buf_head.predict_addr : 32'h0;
`else
    assign oNEXT_PREDICT      = 1'b0;
    assign oNEXT_PREDICT_ADDR = 32'h0;
`endif

    // Sequencer state, fetch PC and kill counter registers
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= START;
            pc_q    <= P_RESET_PC;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end

    // Next-state: redirect beats flush beats predicted redirect beats issue
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        case (state_q)
            START:   state_d = FETCH;
            FETCH:   state_d = FETCH;
            WAIT:    state_d = WAIT;
            default: state_d = START;
        endcase
        if (iREDIRECT_VALID) begin
            pc_d    = align_word(iREDIRECT_ADDR);
            kill_d  = kill_after;
            state_d = FETCH;
        end else if (iFLUSH) begin
            kill_d  = kill_after;
            state_d = WAIT;
        end else if (pred_hit) begin
            pc_d   = pred_target;
            kill_d = kill_after;
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp_fire && drop_kill) begin
                kill_d = kill_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_multi.sv
// Directed self-checking bench for fetch_multi with a one-cycle memory model.
// Optional feature macro: FETCH_MULTI_PREDICT_EN selects prediction checks.
`timescale 1ns/1ps
module tb_fetch_multi;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        kernel = 1'b0;
    logic        paging = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_busy = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_inst = 32'h0;
    logic        mem_pf = 1'b0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_addr = 32'h0;
    logic        next_valid;
    logic [31:0] next_inst;
    logic [31:0] next_pc;
    logic        next_pf;
    logic        next_kernel;
    logic        next_paging;
    logic        next_predict;
    logic [31:0] next_predict_addr;
    logic        next_lock = 1'b0;
    logic        fetch_stop = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    bit          mem_on = 1'b0;
    logic [31:0] pend[$];
    logic [31:0] acc_log[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_inst[$];
    logic [31:0] cons_paddr[$];
    logic [3:0]  cons_flags[$];
    logic        req_seen;
    logic [31:0] addr_seen;
    logic [31:0] pred_at = 32'hFFFF_FFFF;
    logic [31:0] pred_target = 32'h0;
    logic [31:0] pf_at = 32'hFFFF_FFFF;

    fetch_multi #(
        .P_DEPTH           (4),
        .P_RESET_PC        (32'h0),
        .P_MAX_OUTSTANDING (4)
    ) dut (
        .iCLOCK             (clock),
        .iRESET             (reset),
        .iFLUSH             (flush),
        .iREDIRECT_VALID    (redirect_valid),
        .iREDIRECT_ADDR     (redirect_addr),
        .iKERNEL_MODE       (kernel),
        .iPAGING_ENA        (paging),
        .oMEM_REQ           (mem_req),
        .oMEM_ADDR          (mem_addr),
        .iMEM_BUSY          (mem_busy),
        .iMEM_VALID         (mem_valid),
        .iMEM_INST          (mem_inst),
        .iMEM_PAGEFAULT     (mem_pf),
        .iMEM_PRED_TAKEN    (pred_taken),
        .iMEM_PRED_ADDR     (pred_addr),
        .oNEXT_VALID        (next_valid),
        .oNEXT_INST         (next_inst),
        .oNEXT_PC           (next_pc),
        .oNEXT_PAGEFAULT    (next_pf),
        .oNEXT_KERNEL       (next_kernel),
        .oNEXT_PAGING       (next_paging),
        .oNEXT_PREDICT      (next_predict),
        .oNEXT_PREDICT_ADDR (next_predict_addr),
        .iNEXT_LOCK         (next_lock),
        .iFETCH_STOP        (fetch_stop)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // One clock cycle: drive the memory response, sample, then log the edge
    task automatic tick();
        logic [31:0] cur;
        logic        acc;
        logic        cons;
        logic [31:0] c_pc;
        logic [31:0] c_inst;
        logic [31:0] c_pa;
        logic [3:0]  c_fl;
        @(negedge clock);
        if (mem_on && pend.size() > 0) begin
            cur        = pend.pop_front();
            mem_valid  = 1'b1;
            mem_inst   = ~cur;
            mem_pf     = (cur == pf_at);
            pred_taken = (cur == pred_at);
            pred_addr  = (cur == pred_at) ? pred_target : 32'h0;
        end else begin
            mem_valid  = 1'b0;
            mem_inst   = 32'h0;
            mem_pf     = 1'b0;
            pred_taken = 1'b0;
            pred_addr  = 32'h0;
        end
        #1;
        acc       = mem_req && !mem_busy;
        req_seen  = mem_req;
        addr_seen = mem_addr;
        cons      = next_valid && !next_lock;
        c_pc      = next_pc;
        c_inst    = next_inst;
        c_pa      = next_predict_addr;
        c_fl      = {next_pf, next_kernel, next_paging, next_predict};
        @(posedge clock);
        if (acc) begin
            pend.push_back(addr_seen);
            acc_log.push_back(addr_seen);
        end
        if (cons) begin
            cons_pc.push_back(c_pc);
            cons_inst.push_back(c_inst);
            cons_paddr.push_back(c_pa);
            cons_flags.push_back(c_fl);
        end
        #1;
        n_checks++;
        if (dut.u_ibuf.count > 3'd4) begin
            n_fail++;
            $display("[TB] FAIL buffer_bound count=%0d limit=4", dut.u_ibuf.count);
        end
    endtask

    task automatic clear_logs();
        acc_log.delete();
        cons_pc.delete();
        cons_inst.delete();
        cons_paddr.delete();
        cons_flags.delete();
    endtask

    // Reset with all controls idle; returns just after release
    task automatic do_reset();
        reset          = 1'b1;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        mem_busy       = 1'b0;
        next_lock      = 1'b0;
        fetch_stop     = 1'b0;
        mem_on         = 1'b0;
        pred_at        = 32'hFFFF_FFFF;
        pf_at          = 32'hFFFF_FFFF;
        pend.delete();
        tick();
        tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_req got=%b exp=0", mem_req);
        end
        n_checks++;
        if (next_valid !== 1'b0 || next_pc !== 32'h0 || next_inst !== 32'h0 ||
            next_predict !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_next got=%b/%h/%h/%b exp=0/0/0/0",
                     next_valid, next_pc, next_inst, next_predict);
        end
        n_checks++;
        if (mem_addr !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_addr got=%h exp=0", mem_addr);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (req_seen !== 1'b0) begin
            n_fail++; $display("[TB] FAIL start_req got=%b exp=0", req_seen);
        end
        tick();
        n_checks++;
        if (req_seen !== 1'b1 || addr_seen !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL first_fetch got=%b/%h exp=1/00000000", req_seen, addr_seen);
        end
    endtask

    task automatic test_stream();
        do_reset();
        mem_on = 1'b1;
        kernel = 1'b1;
        paging = 1'b0;
        pf_at  = 32'h14;
        repeat (12) tick();
        n_checks++;
        if (acc_log.size() != 11) begin
            n_fail++; $display("[TB] FAIL stream_req_count got=%0d exp=11", acc_log.size());
        end
        for (int i = 0; i < acc_log.size() && i < 11; i++) begin
            n_checks++;
            if (acc_log[i] !== 32'(4 * i)) begin
                n_fail++;
                $display("[TB] FAIL stream_req[%0d] got=%h exp=%h", i, acc_log[i], 32'(4 * i));
            end
        end
        n_checks++;
        if (cons_pc.size() != 9) begin
            n_fail++; $display("[TB] FAIL stream_out_count got=%0d exp=9", cons_pc.size());
        end
        for (int i = 0; i < cons_pc.size() && i < 9; i++) begin
            n_checks++;
            if (cons_pc[i] !== 32'(4 * i) || cons_inst[i] !== ~32'(4 * i)) begin
                n_fail++;
                $display("[TB] FAIL stream_out[%0d] got=%h/%h exp=%h/%h", i,
                         cons_pc[i], cons_inst[i], 32'(4 * i), ~32'(4 * i));
            end
            n_checks++;
            if (cons_flags[i] !== ((i == 5) ? 4'b1100 : 4'b0100)) begin
                n_fail++;
                $display("[TB] FAIL stream_flags[%0d] got=%b exp=%b", i, cons_flags[i],
                         (i == 5) ? 4'b1100 : 4'b0100);
            end
        end
    endtask

    task automatic test_busy();
        do_reset();
        mem_on   = 1'b1;
        mem_busy = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (acc_log.size() != 0 || req_seen !== 1'b1 || addr_seen !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL busy_hold got=%0d/%b/%h exp=0/1/00000000",
                     acc_log.size(), req_seen, addr_seen);
        end
        mem_busy = 1'b0;
        tick();
        tick();
        n_checks++;
        if (acc_log.size() != 2 || addr_seen !== 32'h4) begin
            n_fail++;
            $display("[TB] FAIL busy_release got=%0d/%h exp=2/00000004", acc_log.size(), addr_seen);
        end
    endtask

    task automatic test_lock();
        do_reset();
        mem_on    = 1'b1;
        next_lock = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (acc_log.size() != 4) begin
            n_fail++; $display("[TB] FAIL lock_req_count got=%0d exp=4", acc_log.size());
        end else begin
            n_checks++;
            if (acc_log[3] !== 32'hC) begin
                n_fail++; $display("[TB] FAIL lock_last_req got=%h exp=0000000c", acc_log[3]);
            end
        end
        n_checks++;
        if (req_seen !== 1'b0 || next_valid !== 1'b1 || next_pc !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL lock_hold got=%b/%b/%h exp=0/1/00000000",
                     req_seen, next_valid, next_pc);
        end
        next_lock = 1'b0;
        tick();
        n_checks++;
        if (req_seen !== 1'b0 || cons_pc.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL unlock_first got=%b/%0d exp=0/1", req_seen, cons_pc.size());
        end
        tick();
        n_checks++;
        if (req_seen !== 1'b1 || addr_seen !== 32'h10) begin
            n_fail++;
            $display("[TB] FAIL unlock_reissue got=%b/%h exp=1/00000010", req_seen, addr_seen);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (4) tick();
        n_checks++;
        if (acc_log.size() != 3) begin
            n_fail++; $display("[TB] FAIL redir_setup got=%0d exp=3", acc_log.size());
        end
        clear_logs();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h1003;
        mem_on         = 1'b1;
        tick();
        n_checks++;
        if (req_seen !== 1'b0) begin
            n_fail++; $display("[TB] FAIL redir_no_issue got=%b exp=0", req_seen);
        end
        redirect_valid = 1'b0;
        repeat (8) tick();
        n_checks++;
        if (acc_log.size() < 1 || acc_log[0] !== 32'h1000) begin
            n_fail++;
            $display("[TB] FAIL redir_req got=%h exp=00001000",
                     (acc_log.size() > 0) ? acc_log[0] : 32'hFFFF_FFFF);
        end
        n_checks++;
        if (cons_pc.size() < 2 || cons_pc[0] !== 32'h1000 || cons_pc[1] !== 32'h1004) begin
            n_fail++;
            $display("[TB] FAIL redir_out got=%0d/%h exp=>=2/00001000", cons_pc.size(),
                     (cons_pc.size() > 0) ? cons_pc[0] : 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_flush();
        bit saw_req;
        do_reset();
        mem_on = 1'b1;
        repeat (5) tick();
        flush = 1'b1;
        tick();
        n_checks++;
        if (req_seen !== 1'b0) begin
            n_fail++; $display("[TB] FAIL flush_no_issue got=%b exp=0", req_seen);
        end
        flush = 1'b0;
        n_checks++;
        if (next_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL flush_cleared got=%b exp=0", next_valid);
        end
        clear_logs();
        saw_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_req = saw_req | req_seen;
        end
        n_checks++;
        if (saw_req !== 1'b0 || cons_pc.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL wait_idle got=%b/%0d exp=0/0", saw_req, cons_pc.size());
        end
        redirect_valid = 1'b1;
        redirect_addr  = 32'h200;
        tick();
        redirect_valid = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (acc_log.size() < 1 || acc_log[0] !== 32'h200 ||
            cons_pc.size() < 1 || cons_pc[0] !== 32'h200) begin
            n_fail++;
            $display("[TB] FAIL flush_resume got=%0d/%0d exp=req and out at 00000200",
                     acc_log.size(), cons_pc.size());
        end
    endtask

    task automatic test_predict();
        logic [31:0] exp_third;
        logic [3:0]  exp_flags;
        logic [31:0] exp_paddr;
        logic [31:0] exp_sixth_req;
        do_reset();
        kernel      = 1'b0;
        paging      = 1'b1;
        pred_at     = 32'h8;
        pred_target = 32'h40;
        mem_on      = 1'b1;
        tick();
        tick();
        tick();
        mem_on = 1'b0;
        tick();
        tick();
        mem_on = 1'b1;
        repeat (10) tick();
`ifdef FETCH_MULTI_PREDICT_EN
        exp_third     = 32'h40;
        exp_flags     = 4'b0011;
        exp_paddr     = 32'h40;
        exp_sixth_req = 32'h40;
`else
        exp_third     = 32'hC;
        exp_flags     = 4'b0010;
        exp_paddr     = 32'h0;
        exp_sixth_req = 32'h14;
`endif
        n_checks++;
        if (cons_pc.size() < 4 || cons_pc[0] !== 32'h0 || cons_pc[1] !== 32'h4 ||
            cons_pc[2] !== 32'h8 || cons_pc[3] !== exp_third) begin
            n_fail++;
            $display("[TB] FAIL pred_order got=%0d/%h exp=>=4/%h", cons_pc.size(),
                     (cons_pc.size() > 3) ? cons_pc[3] : 32'hFFFF_FFFF, exp_third);
        end
        n_checks++;
        if (cons_flags.size() < 3 || cons_flags[2] !== exp_flags || cons_paddr[2] !== exp_paddr) begin
            n_fail++;
            $display("[TB] FAIL pred_entry got=%b/%h exp=%b/%h",
                     (cons_flags.size() > 2) ? cons_flags[2] : 4'hF,
                     (cons_paddr.size() > 2) ? cons_paddr[2] : 32'hFFFF_FFFF,
                     exp_flags, exp_paddr);
        end
        n_checks++;
        if (acc_log.size() < 6 || acc_log[5] !== exp_sixth_req) begin
            n_fail++;
            $display("[TB] FAIL pred_next_req got=%h exp=%h",
                     (acc_log.size() > 5) ? acc_log[5] : 32'hFFFF_FFFF, exp_sixth_req);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3) tick();
        n_checks++;
        if (acc_log.size() != 2) begin
            n_fail++; $display("[TB] FAIL rstmid_setup got=%0d exp=2", acc_log.size());
        end
        reset      = 1'b1;
        fetch_stop = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || next_valid !== 1'b0 || mem_addr !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_async got=%b/%b/%h exp=0/0/00000000",
                     mem_req, next_valid, mem_addr);
        end
        tick();
        reset  = 1'b0;
        mem_on = 1'b1;
        clear_logs();
        tick();
        tick();
        n_checks++;
        if (next_valid !== 1'b0 || req_seen !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_late_resp got=%b/%b exp=0/0", next_valid, req_seen);
        end
        fetch_stop = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (acc_log.size() < 1 || acc_log[0] !== 32'h0 ||
            cons_pc.size() < 1 || cons_pc[0] !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_restart got=%0d/%0d exp=req and out at 00000000",
                     acc_log.size(), cons_pc.size());
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_stream();
        test_busy();
        test_lock();
        test_redirect();
        test_flush();
        test_predict();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
